// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  // Operation phases: waiting for operands, iterating, holding the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bits needed for an iteration counter that runs 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_twos_negate.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the product sign. Negating zero yields zero, and the most
// negative value maps onto its own bit pattern, which reads correctly as an
// unsigned magnitude.
module twos_negate #(
  parameter int W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + {{(W-1){1'b0}}, 1'b1}) : x_i;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes.
// Operands are converted to magnitudes at accept, multiplied unsigned over
// WIDTH cycles, and the sign is reapplied on the final iteration.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out one bit per iteration as product bits shift in.
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [CW-1:0]        cnt_q;
  logic                 sign_q;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       sum;
  logic                 last;

  twos_negate #(.W(WIDTH)) u_mag_a (
    .x_i   (a),
    .neg_i (signed_mode & a[WIDTH-1]),
    .y_o   (mag_a)
  );

  twos_negate #(.W(WIDTH)) u_mag_b (
    .x_i   (b),
    .neg_i (signed_mode & b[WIDTH-1]),
    .y_o   (mag_b)
  );

  // One shift-add step: conditionally add the multiplicand into the upper
  // half (keeping its carry), then shift the whole accumulator right.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  // Sign correction is applied to the result of the final step directly.
  twos_negate #(.W(2*WIDTH)) u_sign_fix (
    .x_i   (acc_d),
    .neg_i (sign_q),
    .y_o   (prod_signed)
  );

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= mag_a;
            acc_q   <= {{WIDTH{1'b0}}, mag_b};
            sign_q  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            p_q     <= prod_signed;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier. It is the sequential successor to the team's 4-bit combinational multiplier.
- Computes a WIDTH x WIDTH product over WIDTH clock cycles.
- Supports a per-operation unsigned or signed (two's-complement) mode.
- Uses valid/ready handshakes on input and output so it can sit between pipelined datapath stages and trade area for latency.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a and b as two's complement; 0 = unsigned.
- out_valid  output  1  product is valid and held.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product.
- busy  output  1  iteration in progress (state BUSY).

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; out_valid=0; p=0; busy=0; in_ready=1.
  - Accumulator and counter cleared.
  - Handshake inputs are ignored while rst=1.
- State machine IDLE -> BUSY -> DONE -> IDLE:
  - in_ready = (state==IDLE).
  - busy = (state==BUSY).
  - out_valid = (state==DONE).
- Accept: on an edge with in_valid && in_ready, the block registers the following and moves to BUSY:
  - |a| and |b| (magnitudes; equal to raw values when signed_mode=0);
  - the result sign = signed_mode & (a[MSB]^b[MSB]);
  - count=0.
- BUSY, each cycle:
  - If multiplier LSB=1, add multiplicand into upper accumulator half; shift right one bit with carry-in. Standard radix-2 shift-add.
  - count increments.
  - On the edge where count reaches WIDTH-1, apply the sign correction (two's-complement negate if sign=1), load p, and go to DONE.
  - Exactly WIDTH BUSY cycles. out_valid rises WIDTH cycles after the accept edge.
- DONE: p and out_valid are held stable until an edge with out_ready=1, then the block returns to IDLE.
  - p keeps its last value in IDLE; it is only meaningful while out_valid=1.
- No accept in the same cycle as output drain: minimum initiation interval is WIDTH+2 cycles.
- Arithmetic: the product always fits in 2*WIDTH bits.
  - Unsigned max: (2^W-1)^2.
  - Signed extreme: (-2^(W-1))^2 = 2^(2W-2). This fits positive in signed 2W bits.
  - Magnitude of -2^(W-1) is 2^(W-1), held in a W-bit unsigned register without overflow.
- Zero operand: still takes WIDTH cycles; p=0 with no negative zero (negating 0 yields 0).
- signed_mode, a and b are sampled only at accept; changes during BUSY/DONE have no effect.
- Reset mid-operation (BUSY or DONE): aborts immediately, the result is discarded, and out_valid drops asynchronously.
- out_ready while not DONE is ignored. in_valid while not IDLE is ignored, and the operation is not queued.

Decomposition:
- Shared package seq_mult_pkg:
  - state enum {IDLE, BUSY, DONE};
  - function for count width = $clog2(WIDTH).
- One natural sub-module: twos_negate (parametrised conditional negate). It is reused for operand magnitude and result sign correction.
- The datapath and FSM stay in seq_multiplier.

Test Plan:
- WIDTH=4 unsigned, a=2 b=11 -> p=22 (0x16); out_valid exactly 4 cycles after accept edge.
- WIDTH=4 unsigned, a=14 b=6 -> p=84 (0x54); signed_mode=1 with the same bits (-2*6) -> p=0xF4 (-12).
- WIDTH=4 signed, a=0x8 b=0x8 (-8*-8) -> p=0x40 (64). a=0x8 b=0x7 -> p=0xC8 (-56). a=0 b=0xF -> p=0x00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. p and out_valid stay stable; in_ready=0; a new in_valid is ignored. Releasing out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst 2 cycles into BUSY. out_valid=0, in_ready=1, busy=0 immediately. A subsequent 12*3 -> p=36 with correct latency.
- WIDTH=8 instance: 255*255 unsigned -> 0xFE01; signed 0x80*0x80 -> 0x4000. Latency is 8 cycles.
